// File: rtl/data_sync_tx_arbiter.sv
// data_sync_tx_arbiter
// Source-domain front end for an enable-based data synchronizer. Several
// requesters share one Async_bus/bus_EN pair. A round-robin arbiter picks one
// word at a time. The word is captured and held on Async_bus while bus_EN is
// driven for the receiver. Words are spaced so the receiver captures each one
// exactly once.
//
// Handshake: a requester raises req_valid[i] and holds req_valid[i] and its
// slice of req_data until it sees req_ready[i]. The word is transferred on the
// rising CLK edge where req_valid[i] & req_ready[i] is true. req_ready is
// one-hot and is only offered in IDLE, and it never depends on req_ready
// itself.
module data_sync_tx_arbiter #(
  parameter int Width       = 8,
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 6,
  parameter int S_TO_F      = 1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*Width-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [Width-1:0]           Async_bus,
  output logic                       bus_EN,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [Width-1:0]  win_data;
  logic              take;

  // Round-robin search: start one past the last grant and wrap modulo NUM_REQ.
  always_comb begin
    logic [PW:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      if (!win_found && req_valid[sum[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PW-1:0];
      end
    end
  end

  // Select the winner's data slice.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PW'(k) == win_idx) win_data = req_data[k*Width +: Width];
    end
  end

  // Offer a one-hot ready only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (Reset && (state == IDLE) && win_found) req_ready[win_idx] = 1'b1;
  end

  assign take      = (state == IDLE) && win_found;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Sequencer: capture the word, then run the bus_EN assert and gap phases.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      Async_bus <= '0;
      bus_EN    <= 1'b0;
      grant_id  <= '0;
      ptr       <= PW'(NUM_REQ - 1);
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            Async_bus <= win_data;
            grant_id  <= win_idx;
            ptr       <= win_idx;
            cnt       <= CNT_LOAD;
            state     <= ASSERT;
            bus_EN    <= (S_TO_F != 0) ? 1'b1 : ~bus_EN;
          end
        end
        ASSERT: begin
          if (cnt == '0) begin
            if (S_TO_F != 0) begin
              bus_EN <= 1'b0;
              cnt    <= CNT_LOAD;
              state  <= GAP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Bench for data_sync_tx_arbiter. Three instances share one source clock:
//  inst 0: level mode, HOLD 6, receiver at 3x the source clock
//  inst 1: toggle mode, HOLD 4, receiver at 3x the source clock
//  inst 2: toggle mode, HOLD 12, receiver at 1/3 the source clock
// A cycle-level reference model predicts ready/busy/enable/bus/grant values.
// Accepted words are pushed to a per-instance expected queue, and each
// receiver model pops that queue when it detects an enable event.
module tb_data_sync_tx_arbiter;
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int NI = 3;

  logic clk, rx_fast, rx_slow, rst_n;
  logic [N-1:0]   rv  [NI];
  logic [N*W-1:0] rd  [NI];
  logic [N-1:0]   rr  [NI];
  logic [W-1:0]   ab  [NI];
  logic           en  [NI];
  logic           gid [NI];
  logic           bsy [NI];
  logic [1:0]     st  [NI];

  data_sync_tx_arbiter #(.Width(W), .NUM_REQ(N), .HOLD_CYCLES(6), .S_TO_F(1)) u_lvl (
    .CLK(clk), .Reset(rst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
    .Async_bus(ab[0]), .bus_EN(en[0]), .grant_id(gid[0]), .busy(bsy[0]), .state_dbg(st[0]));
  data_sync_tx_arbiter #(.Width(W), .NUM_REQ(N), .HOLD_CYCLES(4), .S_TO_F(0)) u_tgl (
    .CLK(clk), .Reset(rst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
    .Async_bus(ab[1]), .bus_EN(en[1]), .grant_id(gid[1]), .busy(bsy[1]), .state_dbg(st[1]));
  data_sync_tx_arbiter #(.Width(W), .NUM_REQ(N), .HOLD_CYCLES(12), .S_TO_F(0)) u_slow (
    .CLK(clk), .Reset(rst_n), .req_valid(rv[2]), .req_data(rd[2]), .req_ready(rr[2]),
    .Async_bus(ab[2]), .bus_EN(en[2]), .grant_id(gid[2]), .busy(bsy[2]), .state_dbg(st[2]));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #6 clk = ~clk;
  end
  initial begin
    rx_fast = 1'b0;
    #1;
    forever #2 rx_fast = ~rx_fast;
  end
  initial begin
    rx_slow = 1'b0;
    #1;
    forever #18 rx_slow = ~rx_slow;
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q [NI][$];
  int rx_cnt  [NI];
  int acc_cnt [NI];

  // requester sources
  logic [W-1:0] src_mem [NI][N][64];
  int hd [NI][N];
  int tl [NI][N];

  // reference model
  int           m_left [NI];
  int           m_ptr  [NI];
  logic         m_en   [NI];
  logic [W-1:0] m_bus  [NI];
  int           m_gid  [NI];
  int           win    [NI];

  function automatic int hold_of(input int k);
    case (k)
      0:       return 6;
      1:       return 4;
      default: return 12;
    endcase
  endfunction

  function automatic bit level_mode(input int k);
    return (k == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic rx_got(input int k, input logic [W-1:0] word);
    rx_cnt[k]++;
    if (exp_q[k].size() == 0) check($sformatf("rx_extra%0d", k), word, 32'hFFFF_FFFF);
    else                      check($sformatf("rx_word%0d", k), word, exp_q[k].pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < N; i++) begin
        if (hd[k][i] < tl[k][i]) begin
          rv[k][i]         = 1'b1;
          rd[k][i*W +: W]  = src_mem[k][i][hd[k][i]];
        end else begin
          rv[k][i]         = 1'b0;
          rd[k][i*W +: W]  = W'($urandom_range(0, 255));
        end
      end
    end
  endtask

  task automatic load(input int k, input int i, input logic [W-1:0] word);
    src_mem[k][i][tl[k][i]] = word;
    tl[k][i]++;
    drive_inputs();
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_left[k]  = 0;
      m_ptr[k]   = N - 1;
      m_en[k]    = 1'b0;
      m_bus[k]   = '0;
      m_gid[k]   = 0;
      win[k]     = -1;
      rx_cnt[k]  = 0;
      acc_cnt[k] = 0;
      exp_q[k].delete();
    end
  endtask

  // One source cycle: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic [31:0] exp_rr;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      win[k] = -1;
      if (rst_n && m_left[k] == 0) begin
        for (int j = 1; j <= N; j++) begin
          int idx;
          idx = (m_ptr[k] + j) % N;
          if (win[k] < 0 && rv[k][idx]) win[k] = idx;
        end
      end
      exp_rr = (win[k] >= 0) ? (32'd1 << win[k]) : 32'd0;
      check($sformatf("ready%0d", k), 32'(rr[k]), exp_rr);
      check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_left[k] != 0));
      check($sformatf("bus_en%0d", k), 32'(en[k]), 32'(m_en[k]));
      check($sformatf("async_bus%0d", k), 32'(ab[k]), 32'(m_bus[k]));
      check($sformatf("grant_id%0d", k), 32'(gid[k]), 32'(m_gid[k]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (win[k] >= 0) begin
        m_bus[k]  = src_mem[k][win[k]][hd[k][win[k]]];
        m_gid[k]  = win[k];
        m_ptr[k]  = win[k];
        m_left[k] = level_mode(k) ? 2 * hold_of(k) : hold_of(k);
        m_en[k]   = level_mode(k) ? 1'b1 : ~m_en[k];
        exp_q[k].push_back(m_bus[k]);
        hd[k][win[k]]++;
        acc_cnt[k]++;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (level_mode(k) && m_left[k] == hold_of(k)) m_en[k] = 1'b0;
      end
    end
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    int n;
    bit done;
    n = 0;
    forever begin
      done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (m_left[k] != 0 || exp_q[k].size() != 0) done = 1'b0;
        for (int i = 0; i < N; i++) if (hd[k][i] < tl[k][i]) done = 1'b0;
      end
      if (done || n >= budget) break;
      cycle();
      n++;
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- receiver models ----------------
  logic [2:0] sy0, sy1, sy2;
  initial begin
    sy0 = '0;
    sy1 = '0;
    forever begin
      @(posedge rx_fast or negedge rst_n);
      if (!rst_n) begin
        sy0 = '0;
        sy1 = '0;
      end else begin
        if (sy0[1] && !sy0[2]) rx_got(0, ab[0]);
        if (sy1[1] ^ sy1[2])   rx_got(1, ab[1]);
        sy0 = {sy0[1:0], en[0]};
        sy1 = {sy1[1:0], en[1]};
      end
    end
  end
  initial begin
    sy2 = '0;
    forever begin
      @(posedge rx_slow or negedge rst_n);
      if (!rst_n) begin
        sy2 = '0;
      end else begin
        if (sy2[1] ^ sy2[2]) rx_got(2, ab[2]);
        sy2 = {sy2[1:0], en[2]};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < N; i++) begin
        hd[k][i] = 0;
        tl[k][i] = 0;
      end
    end
    model_reset();
    drive_inputs();

    // reset with a pending request, then single word in level mode
    load(0, 0, 8'hA5);
    repeat (3) cycle();
    rst_n = 1'b1;
    drain(100);

    // both requesters continuously valid in level mode
    for (int j = 0; j < 3; j++) begin
      load(0, 0, W'(8'h11 + j));
      load(0, 1, W'(8'h22 + j));
    end
    drain(200);

    // back-to-back words in toggle mode, fast and slow receivers
    load(1, 0, 8'hC1);
    load(1, 0, 8'hC2);
    load(1, 0, 8'hC3);
    load(2, 1, 8'hD1);
    load(2, 0, 8'hD2);
    load(2, 1, 8'hD3);
    drain(200);

    // random traffic on all instances
    repeat (20) begin
      for (int k = 0; k < NI; k++) begin
        if ($urandom_range(0, 1) == 1) load(k, $urandom_range(0, N-1), W'($urandom_range(0, 255)));
      end
      repeat ($urandom_range(0, 15)) cycle();
    end
    drain(3000);
    repeat (20) cycle();

    // reset in the middle of the assert phase
    load(0, 0, 8'h5A);
    load(0, 1, 8'h6B);
    n = 0;
    while (m_left[0] == 0 && n < 50) begin
      cycle();
      n++;
    end
    check("mid_reset_accept", 32'(m_left[0] != 0), 32'd1);
    cycle();
    cycle();
    rst_n = 1'b0;
    model_reset();
    load(0, 0, 8'h5A);
    repeat (3) cycle();
    rst_n = 1'b1;
    drain(200);
    repeat (20) cycle();

    for (int k = 0; k < NI; k++) begin
      check($sformatf("left_in_queue%0d", k), 32'(exp_q[k].size()), 32'd0);
      check($sformatf("rx_count%0d", k), 32'(rx_cnt[k]), 32'(acc_cnt[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
